dmem_banked: RTL

- Parametrised successor to the PU's two-bank data memory (collatz value / running sum).
- Holds NCH independent banks of 2**AW words, each WIDTH bits wide, selected by a channel index.
- Adds a registered read port, an accumulate-write mode (read-add-write in one cycle), and a hardware bank-clear engine.
- The clear engine zero-fills every bank after reset and one bank or all banks on request.
- Sits between the PU datapath and its load/store decode.

---
 rtl/dmem_banked.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dmem_banked.sv
// ---------------------------------------------------------------------------
// dmem_banked
// Banked data memory for the PU: NCH independent banks of 2**AW words of
// WIDTH bits. Provides a registered read port, plain or accumulate writes
// (read-add-write in one cycle) and a clear engine that zero-fills all banks
// after reset, or one bank / all banks on request.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   i_ad            word address
//   i_wd            write data, or addend when i_acc=1
//   i_we, i_acc     write enable; accumulate select (mem <= mem + wd)
//   i_re            read enable
//   i_ch            bank select for read and write
//   i_clr           clear request pulse
//   i_clr_all       with i_clr: 1 = clear every bank, 0 = clear bank i_clr_ch
//   i_clr_ch        bank to clear
//   o_rd            registered read data (zero when not reading)
//   o_rd_valid      o_rd carries a read result
//   o_acc_ovf       pulse: last accumulate carried out of WIDTH bits
//   o_ch_err        pulse: access or clear targeted a bank >= NCH
//   o_busy          clear engine running; all requests ignored
// ---------------------------------------------------------------------------
module dmem_banked #(
  parameter int WIDTH = 32,
  parameter int AW    = 8,
  parameter int NCH   = 2,
  parameter int CHW   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    i_ad,
  input  logic [WIDTH-1:0] i_wd,
  input  logic             i_we,
  input  logic             i_acc,
  input  logic             i_re,
  input  logic [CHW-1:0]   i_ch,
  input  logic             i_clr,
  input  logic             i_clr_all,
  input  logic [CHW-1:0]   i_clr_ch,
  output logic [WIDTH-1:0] o_rd,
  output logic             o_rd_valid,
  output logic             o_acc_ovf,
  output logic             o_ch_err,
  output logic             o_busy
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CLR  = 1'b1
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_cnt;
  logic             r_clrAll;
  logic [CHW-1:0]   r_clrCh;
  logic [WIDTH-1:0] r_rd;
  logic             r_rdValid;
  logic             r_accOvf;
  logic             r_chErr;

  logic [WIDTH-1:0] r_mem [NCH][DEPTH];

  logic             w_chOk;
  logic             w_clrChOk;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH:0]   w_sum;

  assign w_chOk    = 32'(i_ch) < 32'(NCH);
  assign w_clrChOk = 32'(i_clr_ch) < 32'(NCH);

  // Mux the addressed word out of the selected bank; an out-of-range bank
  // yields zero so no illegal index is ever formed.
  always_comb begin
    w_word = '0;
    for (int b = 0; b < NCH; b++) begin
      if (i_ch == CHW'(b)) w_word = r_mem[b][i_ad];
    end
  end

  // One extra bit keeps the carry-out of the accumulate.
  assign w_sum = {1'b0, w_word} + {1'b0, i_wd};

  // Control FSM plus registered outputs. Reset restarts a full all-bank sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_CLR;
      r_cnt     <= '0;
      r_clrAll  <= 1'b1;
      r_clrCh   <= '0;
      r_rd      <= '0;
      r_rdValid <= 1'b0;
      r_accOvf  <= 1'b0;
      r_chErr   <= 1'b0;
    end else begin
      r_rd      <= '0;
      r_rdValid <= 1'b0;
      r_accOvf  <= 1'b0;
      r_chErr   <= 1'b0;
      case (r_state)
        S_CLR: begin
          if (r_cnt == AW'(DEPTH - 1)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (i_re) begin
            r_rdValid <= 1'b1;
            r_rd      <= w_chOk ? w_word : '0;
            if (!w_chOk) r_chErr <= 1'b1;
          end
          if (i_we) begin
            if (w_chOk) begin
              if (i_acc) r_accOvf <= w_sum[WIDTH];
            end else begin
              r_chErr <= 1'b1;
            end
          end
          // A clear accepted alongside an access lets the access finish first.
          if (i_clr) begin
            if (i_clr_all || w_clrChOk) begin
              r_state  <= S_CLR;
              r_cnt    <= '0;
              r_clrAll <= i_clr_all;
              r_clrCh  <= i_clr_ch;
            end else begin
              r_chErr <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Array storage has no reset; the sweep zeroes one address per cycle.
  always_ff @(posedge clk) begin
    if (r_state == S_CLR) begin
      for (int b = 0; b < NCH; b++) begin
        if (r_clrAll || (r_clrCh == CHW'(b))) r_mem[b][r_cnt] <= '0;
      end
    end else if (i_we && w_chOk) begin
      for (int b = 0; b < NCH; b++) begin
        if (i_ch == CHW'(b)) r_mem[b][i_ad] <= i_acc ? w_sum[WIDTH-1:0] : i_wd;
      end
    end
  end

  assign o_rd       = r_rd;
  assign o_rd_valid = r_rdValid;
  assign o_acc_ovf  = r_accOvf;
  assign o_ch_err   = r_chErr;
  assign o_busy     = (r_state == S_CLR);

endmodule
